skid_buffer_n: RTL

Parametrised valid/ready pipeline buffer for DATA_W-bit beats with DEPTH entries of skid storage. up_ready is driven only from registered state, which breaks the ready timing path. Zero-latency bypass applies when storage is empty and downstream is ready. Sits between any two valid/ready stages; DEPTH=1 gives a one-entry skid stage.

---
 rtl/skid_buffer_n.sv | 84 ++++++++
 1 files changed

// File: rtl/skid_buffer_n.sv
// Valid/ready skid buffer: DEPTH-entry circular store, zero-latency bypass when empty.
// Define SKID_BUFFER_N_REG_OUT_EN to remove the bypass and register every beat.
module skid_buffer_n #(
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 2,
  parameter int LEVEL_W = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [DATA_W-1:0]  up_data,
  input  logic               up_valid,
  output logic               up_ready,
  output logic [DATA_W-1:0]  down_data,
  output logic               down_valid,
  input  logic               down_ready,
  output logic [LEVEL_W-1:0] level
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [LEVEL_W-1:0] FULL_LVL = LEVEL_W'(DEPTH);
  localparam logic [PTR_W-1:0]   LAST_PTR = PTR_W'(DEPTH - 1);

  logic [DATA_W-1:0]  mem [DEPTH];
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic [LEVEL_W-1:0] level_q;

  logic empty;
  logic up_fire;
  logic down_fire;
  logic bypass;
  logic enq;
  logic deq;

  // Handshake: a beat transfers on a side exactly when valid && ready are both
  // high at the rising clock edge. up_ready depends on level_q only, so no
  // combinational path exists from down_ready or up_valid back to up_ready.
  assign empty     = (level_q == '0);
  assign up_ready  = (level_q != FULL_LVL);
  assign up_fire   = up_valid && up_ready;
  assign down_fire = down_valid && down_ready;
  assign level     = level_q;

`ifdef SKID_BUFFER_N_REG_OUT_EN
  assign down_valid = !empty;
  assign down_data  = mem[rd_ptr];
  assign bypass     = 1'b0;
`else
  // Stored beats take priority over the live input so ordering is preserved.
  assign down_valid = !empty || up_valid;
  assign down_data  = empty ? up_data : mem[rd_ptr];
  assign bypass     = up_fire && empty && down_ready;
`endif

  assign enq = up_fire && !bypass;
  assign deq = down_fire && !empty;

  always_ff @(posedge clk) begin
    if (enq) begin
      mem[wr_ptr] <= up_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (enq) begin
        wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
      end
      if (deq) begin
        rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
      end
      case ({enq, deq})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

endmodule
